// File: rtl/yuv_gpif_serializer.sv
// YUV422 chunk buffer and 32-bit serializer toward the FX3 GPIF, tagging the last word of each line.
// Optional build macro: YUV_SERIALIZER_BYTE_SWAP_EN byte-reverses every output word.
module yuv_gpif_serializer #(
  parameter int unsigned PIXEL_PER_CLK = 8,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [PIXEL_PER_CLK*16-1:0]   yuv_i,
  input  logic                          yuv_valid_i,
  input  logic                          yuv_line_i,
  output logic [31:0]                   data_o,
  output logic                          data_valid_o,
  input  logic                          data_ready_i,
  output logic                          line_end_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int unsigned CW   = PIXEL_PER_CLK * 16;
  localparam int unsigned WPC  = PIXEL_PER_CLK / 2;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned IdxW = (WPC > 1) ? $clog2(WPC) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WPC - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  // Hold stage
  logic [CW-1:0] hold_data_q, hold_data_d;
  logic          hold_full_q, hold_full_d;
  logic          line_q;
  logic          capture, line_end, push, push_tag;

  // FIFO
  logic [CW:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          full, empty, pop, push_ok;
  logic          overflow_q, overflow_d;
  logic [CW:0]   rd_entry;

  // Serializer
  state_e        state_q, state_d;
  logic [CW-1:0] shift_q, shift_d;
  logic          tag_q, tag_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]   slice;

  assign capture  = yuv_valid_i && yuv_line_i;
  assign line_end = line_q && !yuv_line_i;
  assign push     = hold_full_q && (capture || line_end);
  assign push_tag = line_end;

  always_comb begin
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    if (capture) begin
      hold_data_d = yuv_i;
      hold_full_d = 1'b1;
    end else if (line_end) begin
      hold_full_d = 1'b0;
    end
  end

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A full FIFO still accepts a push when the serializer frees a slot in the same cycle.
  assign push_ok  = push && (!full || pop);
  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    if (push && !push_ok) overflow_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = rd_entry[CW-1:0];
          tag_d   = rd_entry[CW];
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (data_ready_i) begin
          if (idx_q == LastIdx) begin
            // Reload on the last word so back-to-back chunks stream without a bubble.
            if (!empty) begin
              pop     = 1'b1;
              shift_d = rd_entry[CW-1:0];
              tag_d   = rd_entry[CW];
              idx_d   = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            shift_d = shift_q << 32;
            idx_d   = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      line_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      state_q     <= StIdle;
      shift_q     <= '0;
      tag_q       <= 1'b0;
      idx_q       <= '0;
    end else begin
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      line_q      <= yuv_line_i;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      tag_q       <= tag_d;
      idx_q       <= idx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {push_tag, hold_data_q};
  end

  assign slice = shift_q[CW-1 -: 32];

  always_comb begin
    data_o = '0;
    if (state_q == StSend) begin
`ifdef YUV_SERIALIZER_BYTE_SWAP_EN
      data_o = {slice[7:0], slice[15:8], slice[23:16], slice[31:24]};
`else
      data_o = slice;
`endif
    end
  end

  assign data_valid_o = (state_q == StSend);
  assign line_end_o   = (state_q == StSend) && tag_q && (idx_q == LastIdx);
  assign overflow_o   = overflow_q;
  assign fifo_level_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_yuv_gpif_serializer.sv
// Directed bench for yuv_gpif_serializer: scoreboard of expected {line_end, word} pairs.
module tb_yuv_gpif_serializer;

  localparam int unsigned PPC = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW = PPC * 16;
  localparam int unsigned WPC = PPC / 2;

  logic          clk;
  logic          reset_i;
  logic [CW-1:0] yuv_i;
  logic          yuv_valid_i, yuv_line_i, data_ready_i;
  logic [31:0]   data_o;
  logic          data_valid_o, line_end_o, overflow_o;
  logic [$clog2(DEPTH):0] fifo_level_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [32:0] sb[$];
  bit          held_v = 0;
  logic [32:0] held;
  int xfer_cnt = 0, first_xfer = -1, last_xfer = -1;
  bit rnd_ready = 0;

  yuv_gpif_serializer #(.PIXEL_PER_CLK(PPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_i(reset_i), .yuv_i(yuv_i), .yuv_valid_i(yuv_valid_i),
    .yuv_line_i(yuv_line_i), .data_o(data_o), .data_valid_o(data_valid_o),
    .data_ready_i(data_ready_i), .line_end_o(line_end_o), .overflow_o(overflow_o),
    .fifo_level_o(fifo_level_o)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk(input logic [7:0] base);
    logic [CW-1:0] c;
    for (int k = 0; k < CW / 8; k++) c[CW-1-8*k -: 8] = base + 8'(k);
    return c;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef YUV_SERIALIZER_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic expect_chunk(input logic [CW-1:0] c, input bit last);
    for (int w = 0; w < WPC; w++)
      sb.push_back({last && (w == WPC - 1), exp_word(c[CW-1-32*w -: 32])});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) data_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", 64'(sb.size()), 0);
    rnd_ready = 0;
    data_ready_i = 1;
    repeat (3) tick();
    chk("idle_after_drain", data_valid_o, 0);
  endtask

  // Monitor: compare transfers against the scoreboard and check stall stability.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (held_v) begin
        chk("stall_valid", data_valid_o, 1);
        chk("stall_data", {line_end_o, data_o}, held);
        held_v = 0;
      end
      if (data_valid_o) begin
        if (data_ready_i) begin
          chk("sb_nonempty", sb.size() != 0, 1);
          if (sb.size() != 0) chk("word", {line_end_o, data_o}, sb.pop_front());
          if (first_xfer < 0) first_xfer = cyc;
          last_xfer = cyc;
          xfer_cnt++;
        end else begin
          held_v = 1;
          held = {line_end_o, data_o};
        end
      end
    end
  end

  initial begin
    reset_i = 1; yuv_i = '0; yuv_valid_i = 0; yuv_line_i = 0; data_ready_i = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", data_o, 0);
    chk("rst_valid", data_valid_o, 0);
    chk("rst_line_end", line_end_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_level", fifo_level_o, 0);
    reset_i = 0;
    tick();

    // Single two-chunk line
    yuv_line_i = 1; yuv_valid_i = 1; yuv_i = mk(8'h00); expect_chunk(yuv_i, 0);
    tick();
    yuv_i = mk(8'h10); expect_chunk(yuv_i, 1);
    tick();
    yuv_line_i = 0; yuv_valid_i = 0;
    chk("valid_before_pop", data_valid_o, 0);
    yuv_valid_i = 1; // valid outside a line is ignored
    tick();
    yuv_valid_i = 0;
    chk("valid_after_pop", data_valid_o, 1);
    chk("first_word", data_o, exp_word(32'h00010203));
    drain(50);
    chk("no_stray_push", fifo_level_o, 0);

    // Backpressure: 4-chunk line with random ready
    rnd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      yuv_line_i = 1; yuv_valid_i = 1; yuv_i = mk(8'(8'h20 + 16 * i));
      expect_chunk(yuv_i, i == 3);
      tick();
    end
    yuv_line_i = 0; yuv_valid_i = 0;
    drain(200);

    // Back-to-back 1-chunk lines, one idle cycle apart
    xfer_cnt = 0; first_xfer = -1; last_xfer = -1;
    for (int i = 0; i < 4; i++) begin
      yuv_line_i = 1; yuv_valid_i = 1; yuv_i = mk(8'(8'h40 + 16 * i));
      expect_chunk(yuv_i, 1);
      tick();
      yuv_line_i = 0; yuv_valid_i = 0;
      tick();
    end
    drain(100);
    chk("b2b_words", 64'(xfer_cnt), 16);
    chk("b2b_no_bubble", 64'(last_xfer - first_xfer), 64'(xfer_cnt - 1));

    // Overflow: ready low, 10-chunk line; first chunk parks in the shifter, last is dropped
    data_ready_i = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      yuv_line_i = 1; yuv_valid_i = 1; yuv_i = mk(8'(16 * i + 3));
      if (i < DEPTH + 1) expect_chunk(yuv_i, 0);
      tick();
    end
    yuv_line_i = 0; yuv_valid_i = 0;
    chk("ovf_level_full", fifo_level_o, DEPTH);
    chk("ovf_not_yet", overflow_o, 0);
    tick();
    chk("ovf_level_sat", fifo_level_o, DEPTH);
    chk("ovf_set", overflow_o, 1);
    data_ready_i = 1;
    drain(200);
    chk("ovf_sticky", overflow_o, 1);

    // Reset during the second word of a chunk
    yuv_line_i = 1; yuv_valid_i = 1; yuv_i = mk(8'hA0); expect_chunk(yuv_i, 0);
    tick();
    yuv_i = mk(8'hB0); expect_chunk(yuv_i, 1);
    tick();
    yuv_line_i = 0; yuv_valid_i = 0;
    tick();
    chk("rst_pre_valid", data_valid_o, 1);
    tick();
    #2 reset_i = 1;
    #1;
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_valid", data_valid_o, 0);
    chk("mid_rst_line_end", line_end_o, 0);
    chk("mid_rst_overflow", overflow_o, 0);
    chk("mid_rst_level", fifo_level_o, 0);
    sb.delete();
    held_v = 0;
    tick();
    reset_i = 0;
    repeat (3) tick();
    chk("post_rst_quiet", data_valid_o, 0);
    yuv_line_i = 1; yuv_valid_i = 1; yuv_i = mk(8'hC0); expect_chunk(yuv_i, 1);
    tick();
    yuv_line_i = 0; yuv_valid_i = 0;
    drain(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
